fofb_dma_sched: RTL and testbench
=================================

// Module: fofb_dma_sched
// PURPOSE
//  Schedules the per-timeframe FOFB position DMA on the PCIe TX path. On each
//  timeframe end it walks the XY buffer and issues MWr TLP requests, sized to the
//  negotiated max payload, into a host ring of frame slots. After each complete
//  frame it requests an MSI and reports status. It sits between FOFB CC capture
//  and the BMD TX engine; the TX engine reads the payload itself from xy_buf.
// PARAMETERS
//  FRAME_QW     1024  64-bit words per frame (xy_buf depth); frame = 2*FRAME_QW DW
//  MAX_PLD_DW   128   payload ceiling in DW (512 B); mps codes above this clamp to it
// PORTS
//  clk                  in   1   TRN clock, all logic on rising edge
//  rst                  in   1   synchronous reset, active high
//  dma_en_i             in   1   host DMA enable (register bit)
//  bus_mstr_en_i        in   1   cfg_bus_mstr_enable
//  mps_i                in   3   cfg_prg_max_payload_size code (0=128B,1=256B,2=512B..)
//  host_base_i          in   32  ring base byte address; bits [11:0] ignored (forced 0)
//  ring_frames_i        in   8   slots in host ring; 0 treated as 1
//  timeframe_end_rise_i in   1   1-cycle pulse: new frame complete in xy_buf
//  fofb_rxlink_up_i     in   1   FOFB link status
//  wr_req_o             out  1   MWr TLP request to TX engine
//  wr_ack_i             in   1   TX engine accepted request (fields sampled)
//  wr_done_i            in   1   1-cycle pulse: accepted TLP fully transmitted
//  wr_addr_o            out  32  TLP host byte address (DW aligned)
//  wr_len_o             out  10  TLP length in DW
//  wr_buf_addr_o        out  10  first xy_buf QW index of TLP payload
//  irq_req_o            out  1   MSI request after frame written
//  irq_ack_i            in   1   interrupt accepted (cfg_interrupt_rdy)
//  frame_idx_o          out  8   ring slot of last completed frame
//  overrun_cnt_o        out  16  timeframes missed while busy, saturating
//  fofb_dma_ok_o        out  1   DMA healthy
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, slot index 0, counters 0.
//  pld_dw = min(32<<mps_i, MAX_PLD_DW); latched at frame start, fixed for frame.
//  FSM: IDLE -> REQ on timeframe_end_rise_i && dma_en_i && bus_mstr_en_i;
//   the first cycle of REQ latches off_dw=0 and the slot index.
//   REQ: wr_req_o=1, addr = base + slot*FRAME_QW*8 + off_dw*4,
//        len = min(pld_dw, 2*FRAME_QW-off_dw), buf_addr = off_dw/2. Fields
//        stable while wr_req_o high; wr_req_o never withdrawn before wr_ack_i.
//        On wr_ack_i -> WAIT (wr_req_o low next cycle).
//   WAIT: on wr_done_i off_dw += len; if off_dw == 2*FRAME_QW -> IRQ, else REQ.
//        wr_done_i outside WAIT is ignored.
//   IRQ: irq_req_o=1 until irq_ack_i; then frame_idx_o<=slot, slot wraps to 0
//        after ring_frames_i-1 (else +1), -> IDLE.
//  Max one TLP outstanding. Base is 4KB aligned and pld_dw divides 1024, so no
//  TLP crosses a 4KB boundary.
//  Timeframe pulse outside IDLE: overrun_cnt_o += 1 (saturates 0xFFFF), set
//   ovr_flag; frame is dropped, not queued. Pulse in the same cycle as IRQ->IDLE
//   also counts as overrun.
//  dma_en_i or bus_mstr_en_i low mid-frame: pending REQ still completes its
//   ack, in-flight TLP still waits for wr_done_i, then -> IDLE with no IRQ;
//   slot index is not advanced.
//  fofb_dma_ok_o = dma_en_i & bus_mstr_en_i & fofb_rxlink_up_i & ~ovr_flag,
//   registered (1 cycle). ovr_flag clears when a frame reaches IRQ with no
//   overrun since its start, and when dma_en_i is low.
//  rst mid-frame: immediate return to IDLE, all outputs 0; no request completed.
// TESTING
//  mps=0, FRAME_QW=1024, base 0x1000_0000: one pulse -> 64 TLPs, len 32,
//   addr step 0x80, buf_addr step 16, then 1 irq_req_o, frame_idx_o=0.
//  mps=5 (clamp) -> 16 TLPs len 128; ring_frames=3, 4 frames -> slots 0,1,2,0,
//   2nd frame base 0x1000_2000.
//  Pulse during WAIT -> overrun_cnt_o=1, fofb_dma_ok_o low, no extra TLP;
//   next clean frame -> fofb_dma_ok_o back high.
//  wr_ack_i held low 50 cycles -> wr_req_o and fields stable all 50 cycles.
//  dma_en_i drops in WAIT -> wr_done_i accepted, no further req, no irq, slot unchanged.
//  rst asserted in REQ -> next cycle wr_req_o=0, overrun_cnt_o=0, frame_idx_o=0.

Source files
------------

// File: rtl/fofb_dma_sched.sv
// FOFB position DMA scheduler: each timeframe's xy_buf frame is split into
// max-payload MWr requests aimed at one host ring slot, followed by an MSI.
module fofb_dma_sched #(
  parameter int FRAME_QW   = 1024,
  parameter int MAX_PLD_DW = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_en_i,
  input  logic        bus_mstr_en_i,
  input  logic [2:0]  mps_i,
  input  logic [31:0] host_base_i,
  input  logic [7:0]  ring_frames_i,
  input  logic        timeframe_end_rise_i,
  input  logic        fofb_rxlink_up_i,
  output logic        wr_req_o,
  input  logic        wr_ack_i,
  input  logic        wr_done_i,
  output logic [31:0] wr_addr_o,
  output logic [9:0]  wr_len_o,
  output logic [9:0]  wr_buf_addr_o,
  output logic        irq_req_o,
  input  logic        irq_ack_i,
  output logic [7:0]  frame_idx_o,
  output logic [15:0] overrun_cnt_o,
  output logic        fofb_dma_ok_o
);
  localparam int FRAME_DW = 2 * FRAME_QW;
  localparam int OFF_W    = $clog2(FRAME_DW) + 1;
  localparam logic [31:0] SLOT_BYTES = 32'(FRAME_QW * 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_IRQ  = 2'd3
  } state_t;

  state_t           r_state;
  logic [OFF_W-1:0] r_off_dw;
  logic [OFF_W-1:0] r_pld_dw;
  logic [7:0]       r_slot;
  logic             r_ovr_flag;
  logic             r_frame_ovr;

  logic             w_enabled;
  logic             w_start;
  logic             w_overrun;
  logic             w_frame_end;
  logic [OFF_W-1:0] w_pld_now;
  logic [OFF_W-1:0] w_done_off;
  logic [OFF_W-1:0] w_req_off;
  logic [OFF_W-1:0] w_req_pld;
  logic [OFF_W-1:0] w_req_rem;
  logic [OFF_W-1:0] w_req_len;
  logic [31:0]      w_req_addr;
  logic [7:0]       w_last_slot;
  logic [7:0]       w_next_slot;
  logic [11:0]      w_unused_base;

  function automatic logic [OFF_W-1:0] pld_of(input logic [2:0] mps);
    logic [15:0] v_full;
    v_full = 16'd32 << mps;
    return (v_full > 16'(MAX_PLD_DW)) ? OFF_W'(MAX_PLD_DW) : OFF_W'(v_full);
  endfunction

  // Ring slots are 4 KB aligned, so the low base bits never reach the address.
  assign w_unused_base = host_base_i[11:0];

  // Next request: a fresh frame starts at offset 0, otherwise continue after the finished TLP.
  always_comb begin
    w_enabled   = dma_en_i & bus_mstr_en_i;
    w_start     = (r_state == S_IDLE) & timeframe_end_rise_i & w_enabled;
    w_overrun   = (r_state != S_IDLE) & timeframe_end_rise_i;
    w_pld_now   = pld_of(mps_i);
    w_done_off  = r_off_dw + OFF_W'(wr_len_o);
    w_frame_end = (w_done_off == OFF_W'(FRAME_DW));
    w_req_off   = (r_state == S_IDLE) ? {OFF_W{1'b0}} : w_done_off;
    w_req_pld   = (r_state == S_IDLE) ? w_pld_now : r_pld_dw;
    w_req_rem   = OFF_W'(FRAME_DW) - w_req_off;
    w_req_len   = (w_req_pld < w_req_rem) ? w_req_pld : w_req_rem;
    w_req_addr  = {host_base_i[31:12], 12'h000} + 32'(r_slot) * SLOT_BYTES
                  + (32'(w_req_off) << 2);
    w_last_slot = (ring_frames_i == 8'd0) ? 8'd0 : ring_frames_i - 8'd1;
    w_next_slot = (r_slot >= w_last_slot) ? 8'd0 : r_slot + 8'd1;
  end

  // Frame walk FSM with overrun and health tracking; every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_off_dw      <= {OFF_W{1'b0}};
      r_pld_dw      <= {OFF_W{1'b0}};
      r_slot        <= 8'd0;
      r_ovr_flag    <= 1'b0;
      r_frame_ovr   <= 1'b0;
      wr_req_o      <= 1'b0;
      wr_addr_o     <= 32'd0;
      wr_len_o      <= 10'd0;
      wr_buf_addr_o <= 10'd0;
      irq_req_o     <= 1'b0;
      frame_idx_o   <= 8'd0;
      overrun_cnt_o <= 16'd0;
      fofb_dma_ok_o <= 1'b0;
    end else begin
      fofb_dma_ok_o <= w_enabled & fofb_rxlink_up_i & ~r_ovr_flag;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_REQ;
            r_off_dw      <= {OFF_W{1'b0}};
            r_pld_dw      <= w_pld_now;
            r_frame_ovr   <= 1'b0;
            wr_req_o      <= 1'b1;
            wr_addr_o     <= w_req_addr;
            wr_len_o      <= 10'(w_req_len);
            wr_buf_addr_o <= 10'(w_req_off >> 1);
          end
        end
        S_REQ: begin
          if (wr_ack_i) begin
            wr_req_o <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wr_done_i) begin
            r_off_dw <= w_done_off;
            if (!w_enabled) begin
              r_state <= S_IDLE;
            end else if (w_frame_end) begin
              r_state   <= S_IRQ;
              irq_req_o <= 1'b1;
              if (!r_frame_ovr) r_ovr_flag <= 1'b0;
            end else begin
              r_state       <= S_REQ;
              wr_req_o      <= 1'b1;
              wr_addr_o     <= w_req_addr;
              wr_len_o      <= 10'(w_req_len);
              wr_buf_addr_o <= 10'(w_req_off >> 1);
            end
          end
        end
        S_IRQ: begin
          if (irq_ack_i) begin
            irq_req_o   <= 1'b0;
            frame_idx_o <= r_slot;
            r_slot      <= w_next_slot;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          wr_req_o  <= 1'b0;
          irq_req_o <= 1'b0;
        end
      endcase
      // A timeframe arriving while busy is dropped and only counted.
      if (w_overrun) begin
        if (overrun_cnt_o != 16'hFFFF) overrun_cnt_o <= overrun_cnt_o + 16'd1;
        r_ovr_flag  <= 1'b1;
        r_frame_ovr <= 1'b1;
      end
      if (!dma_en_i) r_ovr_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fofb_dma_sched.sv
// Bench for fofb_dma_sched: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fofb_dma_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        dma_en_i;
  logic        bus_mstr_en_i;
  logic [2:0]  mps_i;
  logic [31:0] host_base_i;
  logic [7:0]  ring_frames_i;
  logic        timeframe_end_rise_i;
  logic        fofb_rxlink_up_i;
  logic        wr_req_o;
  logic        wr_ack_i;
  logic        wr_done_i;
  logic [31:0] wr_addr_o;
  logic [9:0]  wr_len_o;
  logic [9:0]  wr_buf_addr_o;
  logic        irq_req_o;
  logic        irq_ack_i;
  logic [7:0]  frame_idx_o;
  logic [15:0] overrun_cnt_o;
  logic        fofb_dma_ok_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame progress expressed as DW offset and expected handshakes.
  bit m_busy, m_req, m_wait, m_irq, m_flag, m_fovr, m_ok;
  int m_off, m_pld, m_slot, m_idx, m_ovr;

  bit ack_hold, stray_done;
  int ack_cd, done_cd, irq_cd;

  int          s_tlps, last_tlps;
  logic [31:0] s_first, s_second, last_first, last_second;
  logic [9:0]  s_len, s_sbuf, last_len, last_sbuf;
  logic [31:0] h_addr;
  logic [9:0]  h_len, h_buf;

  fofb_dma_sched dut (
    .clk(clk), .rst(rst), .dma_en_i(dma_en_i), .bus_mstr_en_i(bus_mstr_en_i),
    .mps_i(mps_i), .host_base_i(host_base_i), .ring_frames_i(ring_frames_i),
    .timeframe_end_rise_i(timeframe_end_rise_i), .fofb_rxlink_up_i(fofb_rxlink_up_i),
    .wr_req_o(wr_req_o), .wr_ack_i(wr_ack_i), .wr_done_i(wr_done_i),
    .wr_addr_o(wr_addr_o), .wr_len_o(wr_len_o), .wr_buf_addr_o(wr_buf_addr_o),
    .irq_req_o(irq_req_o), .irq_ack_i(irq_ack_i), .frame_idx_o(frame_idx_o),
    .overrun_cnt_o(overrun_cnt_o), .fofb_dma_ok_o(fofb_dma_ok_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int pld_of(input int mps);
    int p;
    p = 32 << mps;
    if (p > 128) p = 128;
    return p;
  endfunction

  function automatic int exp_len();
    return (m_pld < 2048 - m_off) ? m_pld : 2048 - m_off;
  endfunction

  function automatic logic [31:0] exp_addr();
    return {host_base_i[31:12], 12'h000} + 32'(m_slot * 8192) + 32'(m_off * 4);
  endfunction

  task automatic model_step();
    bit was_busy, en_ok;
    int ring_eff;
    if (rst) begin
      m_busy = 0; m_req = 0; m_wait = 0; m_irq = 0; m_flag = 0; m_fovr = 0; m_ok = 0;
      m_off = 0; m_slot = 0; m_idx = 0; m_ovr = 0;
      return;
    end
    en_ok    = dma_en_i && bus_mstr_en_i;
    was_busy = m_busy;
    m_ok     = en_ok && fofb_rxlink_up_i && !m_flag;
    if (m_req) begin
      if (wr_ack_i) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (wr_done_i) begin
        m_off  = m_off + exp_len();
        m_wait = 0;
        if (!en_ok) m_busy = 0;
        else if (m_off == 2048) begin
          m_irq = 1;
          if (!m_fovr) m_flag = 0;
        end else m_req = 1;
      end
    end else if (m_irq) begin
      if (irq_ack_i) begin
        m_irq    = 0;
        m_busy   = 0;
        m_idx    = m_slot;
        ring_eff = (ring_frames_i == 0) ? 1 : int'(ring_frames_i);
        m_slot   = (m_slot + 1 >= ring_eff) ? 0 : m_slot + 1;
        last_tlps = s_tlps; last_first = s_first; last_second = s_second;
        last_len = s_len; last_sbuf = s_sbuf;
      end
    end
    if (timeframe_end_rise_i) begin
      if (was_busy) begin
        if (m_ovr < 65535) m_ovr++;
        m_flag = 1;
        m_fovr = 1;
      end else if (en_ok) begin
        m_busy = 1; m_req = 1; m_off = 0; m_pld = pld_of(int'(mps_i)); m_fovr = 0;
        s_tlps = 0;
      end
    end
    if (!dma_en_i) m_flag = 0;
  endtask

  task automatic compare();
    chk("wr_req", wr_req_o, m_req);
    if (m_req) begin
      chk("wr_addr", wr_addr_o, exp_addr());
      chk("wr_len", wr_len_o, exp_len());
      chk("wr_buf_addr", wr_buf_addr_o, m_off / 2);
    end
    chk("irq_req", irq_req_o, m_irq);
    chk("frame_idx", frame_idx_o, m_idx);
    chk("overrun_cnt", overrun_cnt_o, m_ovr);
    chk("dma_ok", fofb_dma_ok_o, m_ok);
  endtask

  // TX engine and interrupt controller stand-ins with random response delays.
  task automatic drive_responses();
    wr_ack_i = 0; wr_done_i = 0; irq_ack_i = 0;
    if (m_req && !ack_hold) begin
      if (ack_cd == 0) begin
        wr_ack_i = 1;
        s_tlps++;
        if (s_tlps == 1) begin s_first = wr_addr_o; s_len = wr_len_o; end
        if (s_tlps == 2) begin s_second = wr_addr_o; s_sbuf = wr_buf_addr_o; end
        ack_cd = $urandom_range(0, 3);
      end else ack_cd--;
    end
    if (m_wait) begin
      if (done_cd == 0) begin wr_done_i = 1; done_cd = $urandom_range(0, 3); end
      else done_cd--;
    end else if (stray_done && $urandom_range(0, 7) == 0) wr_done_i = 1;
    if (m_irq) begin
      if (irq_cd == 0) begin irq_ack_i = 1; irq_cd = $urandom_range(0, 4); end
      else irq_cd--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    drive_responses();
  endtask

  task automatic pulse();
    timeframe_end_rise_i = 1;
    tick();
    timeframe_end_rise_i = 0;
  endtask

  task automatic wait_idle(input string what);
    int n = 0;
    while (m_busy && n < 5000) begin tick(); n++; end
    n_checks++;
    if (m_busy) begin n_errors++; $display("FAIL %s: frame still busy after 5000 cycles", what); end
  endtask

  task automatic wait_inflight(input string what);
    int n = 0;
    while (!m_wait && n < 1000) begin tick(); n++; end
    n_checks++;
    if (!m_wait) begin n_errors++; $display("FAIL %s: no TLP in flight after 1000 cycles", what); end
  endtask

  initial begin
    automatic int exp_idx[4] = '{0, 1, 2, 0};
    rst = 1; dma_en_i = 1; bus_mstr_en_i = 1; mps_i = 3'd0; host_base_i = 32'h1000_0ABC;
    ring_frames_i = 8'd4; timeframe_end_rise_i = 0; fofb_rxlink_up_i = 1;
    wr_ack_i = 0; wr_done_i = 0; irq_ack_i = 0;
    ack_hold = 0; stray_done = 0; ack_cd = 0; done_cd = 0; irq_cd = 0; s_tlps = 0;
    tick(); tick();
    chk("rst_wr_req", wr_req_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_ok", fofb_dma_ok_o, 0);
    rst = 0;
    tick();

    // mps=0: 64 TLPs of 32 DW
    pulse();
    wait_idle("frame_mps0");
    chk("mps0_tlps", last_tlps, 64);
    chk("mps0_first_addr", last_first, 32'h1000_0000);
    chk("mps0_second_addr", last_second, 32'h1000_0080);
    chk("mps0_second_buf", last_sbuf, 16);
    chk("mps0_len", last_len, 32);
    chk("mps0_frame_idx", frame_idx_o, 0);

    // Clamped payload, 3-slot ring over 4 frames
    rst = 1; tick(); rst = 0; tick();
    mps_i = 3'd5; ring_frames_i = 8'd3; stray_done = 1;
    for (int f = 0; f < 4; f++) begin
      pulse();
      wait_idle("frame_ring");
      chk("ring_tlps", last_tlps, 16);
      chk("ring_len", last_len, 128);
      chk("ring_frame_idx", frame_idx_o, exp_idx[f]);
      if (f == 1) chk("ring_slot1_addr", last_first, 32'h1000_2000);
    end

    // Timeframe while a TLP is in flight
    pulse();
    wait_inflight("ovr");
    pulse();
    tick(); tick();
    chk("ovr_cnt", overrun_cnt_o, 1);
    chk("ovr_ok_low", fofb_dma_ok_o, 0);
    wait_idle("ovr_frame");
    chk("ovr_tlps", last_tlps, 16);
    pulse();
    wait_idle("clean_frame");
    tick();
    chk("clean_ok_high", fofb_dma_ok_o, 1);

    // Ack withheld 50 cycles
    ack_hold = 1;
    pulse();
    h_addr = wr_addr_o; h_len = wr_len_o; h_buf = wr_buf_addr_o;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_req", wr_req_o, 1);
      chk("hold_addr", wr_addr_o, h_addr);
      chk("hold_len", wr_len_o, h_len);
      chk("hold_buf", wr_buf_addr_o, h_buf);
    end
    ack_hold = 0;
    wait_idle("hold_frame");
    chk("hold_frame_idx", frame_idx_o, 0);

    // DMA disabled mid-frame: no irq, slot not advanced
    pulse();
    wait_inflight("abort");
    dma_en_i = 0;
    wait_idle("abort_frame");
    repeat (5) tick();
    chk("abort_frame_idx", frame_idx_o, 0);
    dma_en_i = 1;
    tick();
    pulse();
    wait_idle("after_abort");
    chk("after_abort_addr", last_first, 32'h1000_2000);
    chk("after_abort_idx", frame_idx_o, 1);

    // Reset while requesting
    ack_hold = 1;
    pulse();
    rst = 1;
    tick();
    chk("rstreq_wr_req", wr_req_o, 0);
    chk("rstreq_overrun", overrun_cnt_o, 0);
    chk("rstreq_frame_idx", frame_idx_o, 0);
    rst = 0; ack_hold = 0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (!m_busy && $urandom_range(0, 19) == 0) begin
        host_base_i   = $urandom();
        ring_frames_i = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 49) == 0) mps_i = 3'($urandom_range(0, 7));
      if (dma_en_i && $urandom_range(0, 399) == 0) dma_en_i = 0;
      else if (!dma_en_i && $urandom_range(0, 29) == 0) dma_en_i = 1;
      if (bus_mstr_en_i && $urandom_range(0, 999) == 0) bus_mstr_en_i = 0;
      else if (!bus_mstr_en_i && $urandom_range(0, 19) == 0) bus_mstr_en_i = 1;
      if ($urandom_range(0, 299) == 0) fofb_rxlink_up_i = ~fofb_rxlink_up_i;
      timeframe_end_rise_i = ($urandom_range(0, 119) == 0);
      tick();
    end
    timeframe_end_rise_i = 0; dma_en_i = 1; bus_mstr_en_i = 1;
    wait_idle("random_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
